// File: rtl/pa_dtu_dbginfo_ring.sv
// -----------------------------------------------------------------------------
// pa_dtu_dbginfo_ring
//   Multi-snapshot debug-info capture ring. Each dbg_record pulse stores the
//   wide debug vector in a circular buffer of SNAP_DEPTH entries. CP0 drains
//   the oldest entry one READ_WIDTH-bit word at a time through a 32-bit window.
//   The buffer can either overwrite the oldest entry when full (mode=0) or
//   drop new records (mode=1). Both cases set a sticky overflow flag.
//
// Ports
//   forever_cpuclk     free-running clock
//   cpurst_b           asynchronous active-low reset
//   dbg_info_in        debug vector captured on dbg_record
//   dbg_record         capture trigger
//   cp0_dtu_rreg       CP0 read strobe  (data window at 12'hfe1)
//   cp0_dtu_wreg       CP0 write strobe (control at 12'hfe2: [0]=mode, [1]=clear)
//   cp0_dtu_addr       CP0 register address
//   cp0_dtu_wdata      CP0 write data
//   dbgfifo_regs_data  read window {slice, rptr}
//   dbgfifo_status     {8'b0, wptr, rptr, count, mode, overflow, full, empty}
// -----------------------------------------------------------------------------
module pa_dtu_dbginfo_ring #(
  parameter int INFO_WIDTH = 298,
  parameter int SNAP_DEPTH = 4,
  parameter int RPTR_WIDTH = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [INFO_WIDTH-1:0] dbg_info_in,
  input  logic                  dbg_record,
  input  logic                  cp0_dtu_rreg,
  input  logic                  cp0_dtu_wreg,
  input  logic [11:0]           cp0_dtu_addr,
  input  logic [31:0]           cp0_dtu_wdata,
  output logic [31:0]           dbgfifo_regs_data,
  output logic [31:0]           dbgfifo_status
);

  localparam int READ_WIDTH = 32 - RPTR_WIDTH;
  localparam int WORDS      = (INFO_WIDTH + READ_WIDTH - 1) / READ_WIDTH;
  // Pad to every word the read pointer can name, so the slice never indexes
  // past the end of the vector.
  localparam int PAD_WIDTH  = (2 ** RPTR_WIDTH) * READ_WIDTH;
  localparam int PTR_W      = $clog2(SNAP_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [RPTR_WIDTH-1:0] LAST_WORD = RPTR_WIDTH'(WORDS - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(SNAP_DEPTH);

  logic [PTR_W-1:0]      r_wptr;
  logic [CNT_W-1:0]      r_count;
  logic [RPTR_WIDTH-1:0] r_rptr;
  logic                  r_overflow;
  logic                  r_mode;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_clr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_adv;
  logic                  w_pop;
  logic                  w_store;
  logic                  w_overwrite;
  logic                  w_ovf_evt;
  logic [CNT_W-1:0]      w_count_next;
  logic [PTR_W-1:0]      w_oldest;
  logic [INFO_WIDTH-1:0] w_entry [SNAP_DEPTH];
  logic [PAD_WIDTH-1:0]  w_padded;
  logic [READ_WIDTH-1:0] w_slice;

  assign w_rd    = cp0_dtu_rreg && (cp0_dtu_addr == 12'hfe1);
  assign w_wr    = cp0_dtu_wreg && (cp0_dtu_addr == 12'hfe2);
  assign w_clr   = w_wr && cp0_dtu_wdata[1];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  assign w_rd_adv = w_rd && !w_empty;
  // Last-word read retires the oldest entry.
  assign w_pop    = w_rd_adv && (r_rptr == LAST_WORD);

  // A record is stored if there is room, if the same-cycle pop frees a slot,
  // or if overwrite mode lets it replace the oldest entry. Clear wins.
  assign w_store     = !w_clr && dbg_record && (!w_full || w_pop || !r_mode);
  assign w_overwrite = !w_clr && dbg_record && w_full && !w_pop && !r_mode;
  assign w_ovf_evt   = !w_clr && dbg_record && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_store && !w_pop && !w_overwrite) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_store) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // When full the low count bits are zero, so oldest collapses onto wptr.
  assign w_oldest = r_wptr - r_count[PTR_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < SNAP_DEPTH; gi++) begin : g_entry
      logic [INFO_WIDTH-1:0] r_data;
      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          r_data <= '0;
        end else if (w_store && (r_wptr == PTR_W'(gi))) begin
          r_data <= dbg_info_in;
        end
      end
      assign w_entry[gi] = r_data;
    end
  endgenerate

  assign w_padded = PAD_WIDTH'(w_entry[w_oldest]);
  assign w_slice  = w_padded[READ_WIDTH*r_rptr +: READ_WIDTH];

  assign dbgfifo_regs_data = {(w_empty ? {READ_WIDTH{1'b0}} : w_slice), r_rptr};
  assign dbgfifo_status    = {8'd0, 8'(r_wptr), 4'(r_rptr), 8'(r_count),
                              r_mode, r_overflow, w_full, w_empty};

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wptr     <= '0;
      r_count    <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_mode     <= 1'b0;
    end else if (w_clr) begin
      r_wptr     <= '0;
      r_count    <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_mode     <= cp0_dtu_wdata[0];
    end else begin
      // Mode written now only affects records from the next cycle onward.
      if (w_wr) begin
        r_mode <= cp0_dtu_wdata[0];
      end
      if (w_store) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      // An overwrite replaces the entry being read, so restart at word 0.
      if (w_overwrite) begin
        r_rptr <= '0;
      end else if (w_rd_adv) begin
        r_rptr <= w_pop ? '0 : r_rptr + RPTR_WIDTH'(1);
      end
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pa_dtu_dbginfo_ring.sv
module tb_pa_dtu_dbginfo_ring;

  localparam int IW    = 298;
  localparam int DEPTH = 4;
  localparam int RW    = 28;
  localparam int WORDS = 11;

  logic          clk;
  logic          cpurst_b;
  logic [IW-1:0] dbg_info_in;
  logic          dbg_record;
  logic          cp0_dtu_rreg;
  logic          cp0_dtu_wreg;
  logic [11:0]   cp0_dtu_addr;
  logic [31:0]   cp0_dtu_wdata;
  logic [31:0]   dbgfifo_regs_data;
  logic [31:0]   dbgfifo_status;

  pa_dtu_dbginfo_ring dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (cpurst_b),
    .dbg_info_in       (dbg_info_in),
    .dbg_record        (dbg_record),
    .cp0_dtu_rreg      (cp0_dtu_rreg),
    .cp0_dtu_wreg      (cp0_dtu_wreg),
    .cp0_dtu_addr      (cp0_dtu_addr),
    .cp0_dtu_wdata     (cp0_dtu_wdata),
    .dbgfifo_regs_data (dbgfifo_regs_data),
    .dbgfifo_status    (dbgfifo_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain FIFO of snapshots plus the word cursor.
  logic [IW-1:0] m_q[$];
  int            m_rptr;
  int            m_wptr;
  bit            m_ovf;
  bit            m_mode;

  typedef struct {
    string       name;
    bit          rec;
    bit          rd;
    logic [31:0] exp_data;
    logic [31:0] exp_status;
  } vec_t;

  vec_t          tbl[$];
  logic [IW-1:0] vpat;
  logic [IW-1:0] vv[5];

  function automatic logic [RW-1:0] word_of(input logic [IW-1:0] v, input int k);
    logic [16*RW-1:0] p;
    p = '0;
    p[IW-1:0] = v;
    return p[k*RW +: RW];
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[IW-1:0];
  endfunction

  function automatic logic [31:0] model_data();
    logic [RW-1:0] s;
    s = '0;
    if (m_q.size() > 0) s = word_of(m_q[0], m_rptr);
    return {s, 4'(m_rptr)};
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = m_q.size();
    return {8'd0, 8'(m_wptr), 4'(m_rptr), 8'(n), m_mode, m_ovf,
            (n == DEPTH), (n == 0)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rptr = 0;
    m_wptr = 0;
    m_ovf  = 0;
    m_mode = 0;
  endtask

  task automatic model_update(input bit rec, input logic [IW-1:0] d, input bit rreg,
                              input bit wreg, input logic [11:0] addr,
                              input logic [31:0] wd);
    bit rd, wr;
    rd = rreg && (addr == 12'hfe1);
    wr = wreg && (addr == 12'hfe2);
    if (wr && wd[1]) begin
      m_q.delete();
      m_rptr = 0;
      m_wptr = 0;
      m_ovf  = 0;
      m_mode = wd[0];
    end else begin
      // Read first: a last-word read frees a slot for a same-cycle record.
      if (rd && m_q.size() > 0) begin
        if (m_rptr == WORDS - 1) begin
          void'(m_q.pop_front());
          m_rptr = 0;
        end else begin
          m_rptr++;
        end
      end
      if (rec) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(d);
          m_wptr = (m_wptr + 1) % DEPTH;
        end else if (!m_mode) begin
          void'(m_q.pop_front());
          m_q.push_back(d);
          m_wptr = (m_wptr + 1) % DEPTH;
          m_ovf  = 1;
          m_rptr = 0;
        end else begin
          m_ovf = 1;
        end
      end
      if (wr) m_mode = wd[0];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_data"}, dbgfifo_regs_data, model_data());
    check({name, "_status"}, dbgfifo_status, model_status());
  endtask

  // One clock of stimulus; called just after a rising edge, returns #1 after the next.
  task automatic step(input bit rec, input logic [IW-1:0] d, input bit rreg,
                      input bit wreg, input logic [11:0] addr, input logic [31:0] wd);
    dbg_record    = rec;
    dbg_info_in   = d;
    cp0_dtu_rreg  = rreg;
    cp0_dtu_wreg  = wreg;
    cp0_dtu_addr  = addr;
    cp0_dtu_wdata = wd;
    @(posedge clk);
    #1;
    model_update(rec, d, rreg, wreg, addr, wd);
    dbg_record   = 1'b0;
    cp0_dtu_rreg = 1'b0;
    cp0_dtu_wreg = 1'b0;
  endtask

  task automatic do_rec(input logic [IW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic do_rd();
    step(1'b0, '0, 1'b1, 1'b0, 12'hfe1, 32'h0);
  endtask

  task automatic do_ctl(input logic [31:0] wd);
    step(1'b0, '0, 1'b0, 1'b1, 12'hfe2, wd);
  endtask

  initial begin
    vec_t r;
    cpurst_b      = 1'b0;
    dbg_info_in   = '0;
    dbg_record    = 1'b0;
    cp0_dtu_rreg  = 1'b0;
    cp0_dtu_wreg  = 1'b0;
    cp0_dtu_addr  = '0;
    cp0_dtu_wdata = '0;
    model_reset();

    for (int i = 0; i < IW; i++) vpat[i] = i[0];
    for (int i = 0; i < 5; i++) vv[i] = rand_vec();

    // Table: empty read, then one alternating-bit snapshot drained in 11 reads.
    r = '{"rd_empty", 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001};  tbl.push_back(r);
    r = '{"rec_v",    1'b1, 1'b0, 32'hAAAA_AAA0, 32'h0001_0010};  tbl.push_back(r);
    for (int k = 0; k < 9; k++) begin
      r = '{$sformatf("rd_w%0d", k), 1'b0, 1'b1, {28'hAAAA_AAA, 4'(k + 1)},
            32'h0001_0010 | ((k + 1) << 12)};
      tbl.push_back(r);
    end
    r = '{"rd_w9",  1'b0, 1'b1, 32'h002A_AAAA, 32'h0001_A010};  tbl.push_back(r);
    r = '{"rd_w10", 1'b0, 1'b1, 32'h0000_0000, 32'h0001_0001};  tbl.push_back(r);

    #12;
    check("reset_data", dbgfifo_regs_data, 32'h0);
    check("reset_status", dbgfifo_status, 32'h1);
    @(posedge clk);
    #1;
    cpurst_b = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rec, vpat, tbl[i].rd, 1'b0, tbl[i].rd ? 12'hfe1 : 12'h0, 32'h0);
      check({tbl[i].name, "_data"}, dbgfifo_regs_data, tbl[i].exp_data);
      check({tbl[i].name, "_status"}, dbgfifo_status, tbl[i].exp_status);
    end

    // Overwrite mode: five records into four slots, drain V1..V4 in order.
    do_ctl(32'h2);
    for (int i = 0; i < 5; i++) do_rec(vv[i]);
    check_model("ovw_full");
    check("ovw_count", 32'(dbgfifo_status[11:4]), 32'd4);
    check("ovw_ovf", 32'(dbgfifo_status[2]), 32'd1);
    for (int e = 1; e < 5; e++) begin
      for (int k = 0; k < WORDS; k++) begin
        check($sformatf("ovw_drain_e%0d_w%0d", e, k), dbgfifo_regs_data,
              {word_of(vv[e], k), 4'(k)});
        do_rd();
      end
    end
    check_model("ovw_drained");

    // Stop-when-full: fifth record dropped.
    do_ctl(32'h3);
    for (int i = 0; i < 5; i++) do_rec(vv[i]);
    check_model("stop_full");
    check("stop_wptr", 32'(dbgfifo_status[23:16]), 32'd0);
    check("stop_ovf", 32'(dbgfifo_status[2]), 32'd1);
    check("stop_oldest", dbgfifo_regs_data, {word_of(vv[0], 0), 4'd0});

    // Torn read restarted by an overwrite.
    do_ctl(32'h2);
    for (int i = 0; i < 4; i++) do_rec(vv[i]);
    for (int i = 0; i < 5; i++) do_rd();
    check("torn_rptr5", 32'(dbgfifo_status[15:12]), 32'd5);
    do_rec(vv[4]);
    check("torn_rptr0", 32'(dbgfifo_status[15:12]), 32'd0);
    check("torn_data", dbgfifo_regs_data, {word_of(vv[1], 0), 4'd0});
    check_model("torn");

    // Last-word read and record in the same cycle while full.
    do_ctl(32'h2);
    for (int i = 0; i < 4; i++) do_rec(vv[i]);
    for (int i = 0; i < 10; i++) do_rd();
    step(1'b1, vv[4], 1'b1, 1'b0, 12'hfe1, 32'h0);
    check("poprec_count", 32'(dbgfifo_status[11:4]), 32'd4);
    check("poprec_ovf", 32'(dbgfifo_status[2]), 32'd0);
    check("poprec_data", dbgfifo_regs_data, {word_of(vv[1], 0), 4'd0});
    check_model("poprec");

    // Clear beats a same-cycle record.
    do_rec(vv[0]);
    step(1'b1, vv[1], 1'b0, 1'b1, 12'hfe2, 32'h2);
    check("clr_rec_status", dbgfifo_status, 32'h1);
    check_model("clr_rec");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit          rec, rreg, wreg;
      logic [11:0] addr;
      logic [31:0] wd;
      rec  = ($urandom_range(0, 99) < 40);
      rreg = ($urandom_range(0, 99) < 60);
      wreg = ($urandom_range(0, 99) < 6);
      addr = rreg ? 12'hfe1 : 12'hfe2;
      if (wreg && (!rreg || $urandom_range(0, 1) == 1)) addr = 12'hfe2;
      if ($urandom_range(0, 99) < 5) addr = 12'hfe0 + 12'($urandom_range(0, 3));
      wd = {$urandom, 2'b0} | 32'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 30) wd[1] = 1'b1;
      else wd[1] = 1'b0;
      step(rec, rand_vec(), rreg, wreg, addr, wd);
      check_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of activity.
    do_ctl(32'h2);
    do_rec(vv[2]);
    do_rd();
    #2;
    cpurst_b = 1'b0;
    #1;
    model_reset();
    check("async_rst_data", dbgfifo_regs_data, 32'h0);
    check("async_rst_status", dbgfifo_status, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
